ram_frame_writer: RTL

//  Fills the 4800x25b frame RAMs (ref/act) from a valid/ready pixel stream.

---
 rtl/ram_frame_writer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ram_frame_writer.sv
// Writes a valid/ready pixel stream into ping-pong frame RAM buffers.
// It reports completed frames and flags malformed frame starts.
module ram_frame_writer #(
    parameter int unsigned DATA_W = 25,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DEPTH  = 4800,
    parameter int unsigned FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    output logic [ADDR_W-1:0] addr_wr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_enm,
    output logic              wr_sel,
    output logic              buf_sel,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_sof,
    output logic              err_drop
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   cnt, cnt_n;
    logic [ADDR_W-1:0]   addr_n, waddr;
    logic [DATA_W-1:0]   data_n;
    logic                wen_n, wsel_n, bsel_n, done_n, esof_n, edrop_n, do_write;
    logic [FCNT_W-1:0]   fcnt_n;
    logic                accept;

    // Ready depends only on state, so a stalled producer can never deadlock us.
    assign s_ready = ~rst & (state != DONE);
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        addr_n   = addr_wr;
        data_n   = wr_data;
        wen_n    = 1'b0;
        wsel_n   = wr_sel;
        bsel_n   = buf_sel;
        done_n   = 1'b0;
        fcnt_n   = frame_cnt;
        esof_n   = 1'b0;
        edrop_n  = 1'b0;
        do_write = 1'b0;
        waddr    = '0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (s_sof) begin
                        do_write = 1'b1;
                        state_n  = WRITE;
                    end else begin
                        edrop_n = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    do_write = 1'b1;
                    esof_n   = s_sof;
                    waddr    = s_sof ? '0 : cnt;
                end
            end
            DONE: begin
                state_n = IDLE;
                bsel_n  = ~buf_sel;
                fcnt_n  = frame_cnt + FCNT_W'(1);
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // A restart via mid-frame SOF rewrites address 0 of the same buffer.
        if (do_write) begin
            wen_n  = 1'b1;
            addr_n = waddr;
            data_n = s_data;
            wsel_n = buf_sel;
            if (waddr == LAST_ADDR) begin
                cnt_n   = '0;
                state_n = DONE;
            end else begin
                cnt_n = waddr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_wr    <= '0;
            wr_data    <= '0;
            wr_enm     <= 1'b0;
            wr_sel     <= 1'b0;
            buf_sel    <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err_sof    <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            addr_wr    <= addr_n;
            wr_data    <= data_n;
            wr_enm     <= wen_n;
            wr_sel     <= wsel_n;
            buf_sel    <= bsel_n;
            frame_done <= done_n;
            frame_cnt  <= fcnt_n;
            err_sof    <= esof_n;
            err_drop   <= edrop_n;
        end
    end

endmodule
